// File: rtl/beam_pkg.sv
// Shared types for the beam DAC path: the pacer state encoding used by
// dac_stream_pacer and exposed on its debug port.
package beam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        PLAY    = 2'd2
    } pacer_state_e;

endpackage

// File: rtl/dac_stream_pacer_if.sv
// Buffer bus between the pacer control (master) and dac_sample_fifo (slave).
// Handshake: push is honoured when !full or when pop is high in the same
// cycle; pop is honoured only when !empty; rdata always shows the head word.
interface dac_stream_pacer_if #(
    parameter int DWIDTH = 32,
    parameter int LW     = 7
);
    logic              push;
    logic [DWIDTH-1:0] wdata;
    logic              pop;
    logic [DWIDTH-1:0] rdata;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;

    modport master (output push, wdata, pop, input rdata, full, empty, level);
    modport slave  (input push, wdata, pop, output rdata, full, empty, level);
endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with a 0..DEPTH level counter, so full and empty are
// distinct; a push is accepted while full if a pop happens in the same cycle.
module dac_sample_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 64
) (
    input  logic clk,
    input  logic rst,
    dac_stream_pacer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = bus.pop && (level_q != '0);
        do_push  = bus.push && ((level_q != LW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level counter guards every read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= bus.wdata;
    end

    assign bus.rdata = mem_q[rd_ptr_q];
    assign bus.full  = (level_q == LW'(DEPTH));
    assign bus.empty = (level_q == '0);
    assign bus.level = level_q;
endmodule

// File: rtl/dac_stream_pacer.sv
// Paces an unstallable sample stream out to a DAC at one word per
// cfg_rate_div+1 cycles after a prefill. Define PACER_UNDERFLOW_HOLD_EN to
// keep the last sample on dac_data across an underflow instead of zeroing it.
module dac_stream_pacer
    import beam_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 64,
    parameter int DIV_WIDTH = 8,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    axis_S_dac_tdata,
    input  logic                 axis_S_dac_tvalid,
    input  logic [DIV_WIDTH-1:0] cfg_rate_div,
    input  logic [LW-1:0]        cfg_prefill,
    input  logic                 clr_flags,
    output logic [DWIDTH-1:0]    dac_data,
    output logic                 dac_strobe,
    output logic                 running,
    output logic [LW-1:0]        fill_level,
    output logic                 overflow,
    output logic                 underflow,
    output pacer_state_e         dbg_state_o
);
    pacer_state_e         state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DWIDTH-1:0]    data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [LW-1:0]        prefill_thr;
    logic                 pop, push, ovf_set, unf_set;

    dac_stream_pacer_if #(.DWIDTH(DWIDTH), .LW(LW)) fifo_bus ();

    dac_sample_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk (clk),
        .rst (rst),
        .bus (fifo_bus)
    );

    assign fifo_bus.push  = push;
    assign fifo_bus.wdata = axis_S_dac_tdata;
    assign fifo_bus.pop   = pop;

    always_comb begin
        if (cfg_prefill > LW'(DEPTH))  prefill_thr = LW'(DEPTH);
        else if (cfg_prefill == '0)    prefill_thr = LW'(1);
        else                           prefill_thr = cfg_prefill;
    end

    // The PREFILL exit cycle is itself the first playback tick, so the first
    // sample leaves without waiting a divider period.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        pop      = 1'b0;
        unf_set  = 1'b0;
        case (state_q)
            PREFILL: begin
                if (fifo_bus.level >= prefill_thr) begin
                    state_d = PLAY;
                    pop     = 1'b1;
                    div_d   = cfg_rate_div;
                    cnt_d   = '0;
                end
            end
            PLAY: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (!fifo_bus.empty) begin
                        pop = 1'b1;
                    end else begin
                        unf_set = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: ;
        endcase

        push    = axis_S_dac_tvalid && (!fifo_bus.full || pop);
        ovf_set = axis_S_dac_tvalid && !push;
        if (state_q == IDLE && push) state_d = PREFILL;

        if (pop) begin
            data_d   = fifo_bus.rdata;
            strobe_d = 1'b1;
        end
`ifndef PACER_UNDERFLOW_HOLD_EN
        else if (unf_set) begin
            data_d = '0;
        end
`endif

        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        unf_d = unf_set | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign dac_data    = data_q;
    assign dac_strobe  = strobe_q;
    assign running     = (state_q == PLAY);
    assign fill_level  = fifo_bus.level;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dac_stream_pacer.sv
// Bench for dac_stream_pacer: directed table, multi-cycle corner sequences and
// random traffic, all checked against a queue-based playback model.
module tb_dac_stream_pacer;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int DIVW  = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PACER_UNDERFLOW_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam int M_IDLE = 0, M_PREFILL = 1, M_PLAY = 2;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   tdata = '0;
    logic            tvalid = 1'b0;
    logic [DIVW-1:0] rate_div = '0;
    logic [LW-1:0]   prefill = LW'(1);
    logic            clr = 1'b0;
    logic [DW-1:0]   dac_data;
    logic            dac_strobe, running, overflow, underflow;
    logic [LW-1:0]   fill_level;
    beam_pkg::pacer_state_e dbg_state;

    always #5 clk = ~clk;

    dac_stream_pacer #(.DWIDTH(DW), .DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk               (clk),
        .rst               (rst),
        .axis_S_dac_tdata  (tdata),
        .axis_S_dac_tvalid (tvalid),
        .cfg_rate_div      (rate_div),
        .cfg_prefill       (prefill),
        .clr_flags         (clr),
        .dac_data          (dac_data),
        .dac_strobe        (dac_strobe),
        .running           (running),
        .fill_level        (fill_level),
        .overflow          (overflow),
        .underflow         (underflow),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds the words the pacer should still emit, oldest first;
    // m_wait counts cycles remaining until the next playback tick.
    logic [DW-1:0] exp_q[$];
    int            m_mode = M_IDLE;
    int            m_wait = 0;
    int            m_div = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_strobe = 0, m_ov = 0, m_un = 0;

    task automatic model_step();
        int thr, next_mode;
        bit pop_now, acc, ov_set, un_set;
        if (rst) begin
            exp_q.delete();
            m_mode = M_IDLE; m_wait = 0; m_div = 0;
            m_data = '0; m_strobe = 0; m_ov = 0; m_un = 0;
        end else begin
            pop_now = 0; acc = 0; ov_set = 0; un_set = 0; m_strobe = 0;
            thr = (int'(prefill) > DEPTH) ? DEPTH : int'(prefill);
            if (thr < 1) thr = 1;
            next_mode = m_mode;
            if (m_mode == M_PREFILL && exp_q.size() >= thr) begin
                pop_now = 1; m_div = int'(rate_div); m_wait = int'(rate_div); next_mode = M_PLAY;
            end else if (m_mode == M_PLAY) begin
                if (m_wait > 0) m_wait--;
                else if (exp_q.size() > 0) begin pop_now = 1; m_wait = m_div; end
                else begin un_set = 1; next_mode = M_IDLE; end
            end
            if (tvalid) begin
                if (exp_q.size() - int'(pop_now) < DEPTH) acc = 1;
                else ov_set = 1;
            end
            if (pop_now) begin
                m_data = exp_q.pop_front();
                m_strobe = 1;
            end else if (un_set && !HOLD) begin
                m_data = '0;
            end
            if (acc) exp_q.push_back(tdata);
            if (m_mode == M_IDLE && acc) next_mode = M_PREFILL;
            m_mode = next_mode;
            m_ov = ov_set | (m_ov & ~clr);
            m_un = un_set | (m_un & ~clr);
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        check("mdl_data", dac_data, m_data);
        check("mdl_strobe", dac_strobe, m_strobe);
        check("mdl_running", running, m_mode == M_PLAY);
        check("mdl_level", fill_level, exp_q.size());
        check("mdl_overflow", overflow, m_ov);
        check("mdl_underflow", underflow, m_un);
        check("mdl_active", dbg_state != beam_pkg::IDLE, m_mode != M_IDLE);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit c);
        tvalid = v; tdata = d; clr = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; logic [DW-1:0] d; bit c;
        bit e_stb; logic [DW-1:0] e_data; bit e_run; int e_lvl; bit e_ov; bit e_un;
    } vec_t;
    vec_t vecs[9];

    logic [DW-1:0] seen_d[$];
    int            seen_t[$];

    task automatic log_strobe(input int cyc);
        if (dac_strobe) begin
            seen_d.push_back(dac_data);
            seen_t.push_back(cyc);
        end
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int first_run, rate, strobes;

        // reset values while rst is held
        @(negedge clk);
        check("rst_data", dac_data, 0);
        check("rst_strobe", dac_strobe, 0);
        check("rst_running", running, 0);
        check("rst_level", fill_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        // directed table: prefill 1, divider 0
        vecs[0] = '{1, 32'h11, 0,        0, 32'h0, 0, 1, 0, 0};
        vecs[1] = '{0, 32'h0, 0,         1, 32'h11, 1, 0, 0, 0};
        vecs[2] = '{0, 32'h0, 0,         0, HOLD ? 32'h11 : 32'h0, 0, 0, 0, 1};
        vecs[3] = '{0, 32'h0, 1,         0, HOLD ? 32'h11 : 32'h0, 0, 0, 0, 0};
        vecs[4] = '{1, 32'h22, 0,        0, HOLD ? 32'h11 : 32'h0, 0, 1, 0, 0};
        vecs[5] = '{1, 32'hA5A5A5A5, 0,  1, 32'h22, 1, 1, 0, 0};
        vecs[6] = '{0, 32'h0, 0,         1, 32'hA5A5A5A5, 1, 0, 0, 0};
        vecs[7] = '{0, 32'h0, 0,         0, HOLD ? 32'hA5A5A5A5 : 32'h0, 0, 0, 0, 1};
        vecs[8] = '{0, 32'h0, 1,         0, HOLD ? 32'hA5A5A5A5 : 32'h0, 0, 0, 0, 0};
        prefill = LW'(1); rate_div = '0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].c);
            check($sformatf("vec%0d_strobe", i), dac_strobe, vecs[i].e_stb);
            check($sformatf("vec%0d_data", i), dac_data, vecs[i].e_data);
            check($sformatf("vec%0d_running", i), running, vecs[i].e_run);
            check($sformatf("vec%0d_level", i), fill_level, vecs[i].e_lvl);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ov);
            check($sformatf("vec%0d_underflow", i), underflow, vecs[i].e_un);
        end

        // prefill 4, divider 2, samples 1..8 back to back
        prefill = LW'(4); rate_div = DIVW'(2);
        do_reset();
        seen_d.delete(); seen_t.delete(); first_run = -1;
        for (int k = 0; k < 40; k++) begin
            drive(k < 8, DW'(k + 1), 0);
            if (running && first_run < 0) first_run = k + 1;
            log_strobe(k + 1);
        end
        check("pf4_running_cycle", first_run, 5);
        check("pf4_strobe_count", seen_d.size(), 8);
        for (int i = 0; i < seen_d.size() && i < 8; i++) begin
            check($sformatf("pf4_sample%0d", i), seen_d[i], i + 1);
            if (i > 0) check($sformatf("pf4_gap%0d", i), seen_t[i] - seen_t[i-1], 3);
        end
        check("pf4_underflow", underflow, 1);

        // 70 samples into a depth-64 buffer during prefill
        prefill = LW'(64); rate_div = DIVW'(3);
        do_reset();
        seen_d.delete(); seen_t.delete();
        for (int k = 0; k < 400; k++) begin
            drive(k < 70, DW'(k + 1), 0);
            if (k == 63) check("ovf_level_full", fill_level, 64);
            log_strobe(k + 1);
        end
        check("ovf_flag", overflow, 1);
        check("ovf_enough_strobes", seen_d.size() >= 64, 1);
        for (int i = 0; i < seen_d.size() && i < 64; i++)
            check($sformatf("ovf_sample%0d", i), seen_d[i], i + 1);

        // full buffer, divider 0, continuous input
        prefill = LW'(64); rate_div = '0;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            drive(1, $urandom, 0);
            if (k >= 63) check("full_level_steady", fill_level, 64);
        end
        check("full_no_overflow", overflow, 0);

        // reset pulsed mid-PLAY with samples queued
        prefill = LW'(12); rate_div = DIVW'(5);
        do_reset();
        for (int k = 0; k < 15; k++) drive(k < 12, DW'(k + 100), 0);
        check("rstmid_running", running, 1);
        check("rstmid_queued", fill_level >= 10, 1);
        rst = 1'b1;
        drive(1, 32'hDEAD, 0);
        rst = 1'b0;
        check("rstmid_data", dac_data, 0);
        check("rstmid_strobe", dac_strobe, 0);
        check("rstmid_running0", running, 0);
        check("rstmid_level", fill_level, 0);
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, '0, 0);
            strobes += int'(dac_strobe);
        end
        check("rstmid_no_strobes", strobes, 0);

        // clr_flags coincident with an overflow drop
        prefill = LW'(64); rate_div = DIVW'(200);
        do_reset();
        for (int k = 0; k < 65; k++) drive(1, DW'(k), 0);
        drive(1, 32'h77, 1);
        check("clr_vs_set_overflow", overflow, 1);
        drive(0, '0, 1);
        check("clr_alone_overflow", overflow, 0);

        // random traffic against the model
        do_reset();
        rate = 50;
        for (int k = 0; k < 4000; k++) begin
            if (k % 200 == 0) rate = $urandom_range(20, 95);
            if ($urandom_range(0, 63) == 0) begin
                prefill = LW'($urandom_range(0, 127));
                rate_div = DIVW'($urandom_range(0, 4));
            end
            rst = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 99) < rate, $urandom, $urandom_range(0, 31) == 0);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
